rx_loop_filter: RTL

- Digital proportional-integral loop filter for the emulated receiver CDR.
- Consumes bang-bang phase-detector votes once per RX clock event.
- Produces the registered, saturated DCO control word that drives the RX clock period; a larger code gives a shorter period (faster clock).
- Includes a two-state lock detector that reduces proportional gain once tracking.

---
 rtl/rx_loop_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rx_loop_filter.sv
// Proportional-integral loop filter for the emulated RX CDR: turns bang-bang
// phase votes into a saturated DCO code, with a lock detector that halves Kp.
module rx_loop_filter #(
  parameter int CODE_WIDTH  = 14,
  parameter int INIT_CODE   = 8192,
  parameter int ACC_WIDTH   = 24,
  parameter int ACC_FRAC    = 8,
  parameter int KI_SHIFT    = 2,
  parameter int KP_SHIFT    = 4,
  parameter int LOCK_WINDOW = 64,
  parameter int LOCK_THRESH = 8,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cke,
  input  logic                  up,
  input  logic                  dn,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  locked
);

  localparam int SW  = ((ACC_WIDTH > CODE_WIDTH) ? ACC_WIDTH : CODE_WIDTH) + 2;
  localparam int WCW = (LOCK_WINDOW > 2) ? $clog2(LOCK_WINDOW) : 1;
  localparam int VSW = $clog2(LOCK_WINDOW + 1) + 1;
  localparam int GCW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

  localparam logic signed [ACC_WIDTH:0] KI_STEP  = (ACC_WIDTH+1)'(1 << KI_SHIFT);
  localparam logic signed [SW-1:0]      KP_ACQ   = SW'(1 << KP_SHIFT);
  localparam logic signed [SW-1:0]      KP_TRK   = SW'(1 << (KP_SHIFT - 1));
  localparam logic signed [SW-1:0]      INIT_SW  = SW'(INIT_CODE);
  localparam logic signed [SW-1:0]      CODE_MAX = SW'((1 << CODE_WIDTH) - 1);
  localparam logic signed [VSW-1:0]     VONE     = VSW'(1);
  localparam logic signed [VSW-1:0]     VTHRESH  = VSW'(LOCK_THRESH);

  typedef enum logic {ACQ, TRACK} state_t;

  state_t                  state, state_n;
  logic [GCW-1:0]          good_cnt, good_n;
  logic [WCW-1:0]          win_cnt;
  logic signed [VSW-1:0]   vsum, vsum_n, vabs;
  logic                    win_end, good;
  logic                    vote_up, vote_dn;
  logic signed [ACC_WIDTH-1:0] acc, acc_n;
  logic signed [ACC_WIDTH:0]   acc_sum;
  logic signed [SW-1:0]    acc_int, p_mag, p_term, code_sum;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] x);
    if (x[ACC_WIDTH] != x[ACC_WIDTH-1])
      sat_acc = x[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sat_acc = x[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [CODE_WIDTH-1:0] clamp_code(input logic signed [SW-1:0] x);
    if (x[SW-1])
      clamp_code = '0;
    else if (x > CODE_MAX)
      clamp_code = '1;
    else
      clamp_code = x[CODE_WIDTH-1:0];
  endfunction

  assign vote_up = up & ~dn;
  assign vote_dn = dn & ~up;

  always_comb begin
    acc_sum  = $signed({acc[ACC_WIDTH-1], acc});
    if (vote_up) acc_sum = acc_sum + KI_STEP;
    if (vote_dn) acc_sum = acc_sum - KI_STEP;
    acc_n    = sat_acc(acc_sum);
    acc_int  = $signed({{(SW-ACC_WIDTH){acc_n[ACC_WIDTH-1]}}, acc_n}) >>> ACC_FRAC;
    p_mag    = (state == TRACK) ? KP_TRK : KP_ACQ;
    p_term   = vote_up ? p_mag : (vote_dn ? -p_mag : '0);
    code_sum = INIT_SW + acc_int + p_term;
  end

  // Lock window: the window-end event's own vote is included in the sum.
  always_comb begin
    vsum_n = vsum;
    if (vote_up) vsum_n = vsum + VONE;
    if (vote_dn) vsum_n = vsum - VONE;
    vabs    = vsum_n[VSW-1] ? -vsum_n : vsum_n;
    good    = (vabs <= VTHRESH);
    win_end = (win_cnt == WCW'(LOCK_WINDOW - 1));
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    if (cke && win_end) begin
      case (state)
        ACQ: begin
          if (!good)
            good_n = '0;
          else if (good_cnt == GCW'(LOCK_COUNT - 1)) begin
            state_n = TRACK;
            good_n  = '0;
          end else
            good_n = good_cnt + GCW'(1);
        end
        TRACK: begin
          if (!good) begin
            state_n = ACQ;
            good_n  = '0;
          end
        end
        default: state_n = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACQ;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      code     <= CODE_WIDTH'(INIT_CODE);
      locked   <= 1'b0;
      win_cnt  <= '0;
      vsum     <= '0;
      good_cnt <= '0;
    end else if (cke) begin
      acc      <= acc_n;
      code     <= clamp_code(code_sum);
      locked   <= (state_n == TRACK);
      win_cnt  <= win_end ? '0 : win_cnt + WCW'(1);
      vsum     <= win_end ? '0 : vsum_n;
      good_cnt <= good_n;
    end
  end

endmodule
